// File: rtl/decod_morse.sv
// rtl/decod_morse.sv - Morse key decoder: sync, debounce, dot/dash timing, letter lookup.
// Raw key goes through sync and debounce, then press/gap timing; letters end after a gap.
module decod_morse #(
  parameter int TICK_DIV    = 50000,
  parameter int DEBOUNCE_TK = 10,
  parameter int DOT_MAX_TK  = 200,
  parameter int GAP_TK      = 600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_in,
  output logic [5:0] num,
  output logic [4:0] morse,
  output logic [4:0] display,
  output logic       valid,
  output logic       err,
  output logic       ponto,
  output logic       traco
);

  localparam int DW = $clog2(TICK_DIV + 1);
  localparam int BW = $clog2(DEBOUNCE_TK + 1);
  localparam logic [11:0] DOT_MAX = 12'(DOT_MAX_TK);
  localparam logic [11:0] GAP_LIM = 12'(GAP_TK);

  typedef enum logic [2:0] {IDLE, PRESS, GAP, SEARCH, DONE} state_t;

  state_t          state;
  logic [DW-1:0]   div;
  logic            tick_en;
  logic [1:0]      sync;
  logic            ksync;
  logic [BW-1:0]   db_cnt;
  logic            k;
  logic [11:0]     dur;
  logic [11:0]     dur_inc;
  logic [4:0]      pat;
  logic [2:0]      sym_cnt;
  logic            ovf;
  logic            hit_q;
  logic [5:0]      idx_q;
  logic [6:0]      lk;

  assign tick_en = (div == DW'(TICK_DIV - 1));
  assign ksync   = sync[1];
  assign dur_inc = (dur == 12'hFFF) ? dur : dur + 12'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div    <= '0;
      sync   <= 2'b00;
      db_cnt <= '0;
      k      <= 1'b0;
    end else begin
      div  <= tick_en ? '0 : div + 1'b1;
      sync <= {sync[0], key_in};
      // level must disagree for DEBOUNCE_TK consecutive ticks before it is taken
      if (ksync == k) begin
        db_cnt <= '0;
      end else if (tick_en) begin
        if (db_cnt == BW'(DEBOUNCE_TK - 1)) begin
          k      <= ksync;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end
    end
  end

  // patterns are left-justified, 1 = dot; result is {hit, index}
  function automatic logic [6:0] lookup(input logic [2:0] len, input logic [4:0] p);
    case ({len, p})
      {3'd2, 5'b10000}: lookup = {1'b1, 6'd0};
      {3'd4, 5'b01110}: lookup = {1'b1, 6'd1};
      {3'd4, 5'b01010}: lookup = {1'b1, 6'd2};
      {3'd3, 5'b01100}: lookup = {1'b1, 6'd3};
      {3'd1, 5'b10000}: lookup = {1'b1, 6'd4};
      {3'd4, 5'b11010}: lookup = {1'b1, 6'd5};
      {3'd3, 5'b00100}: lookup = {1'b1, 6'd6};
      {3'd4, 5'b11110}: lookup = {1'b1, 6'd7};
      {3'd2, 5'b11000}: lookup = {1'b1, 6'd8};
      {3'd4, 5'b10000}: lookup = {1'b1, 6'd9};
      {3'd3, 5'b01000}: lookup = {1'b1, 6'd10};
      {3'd4, 5'b10110}: lookup = {1'b1, 6'd11};
      {3'd2, 5'b00000}: lookup = {1'b1, 6'd12};
      {3'd2, 5'b01000}: lookup = {1'b1, 6'd13};
      {3'd3, 5'b00000}: lookup = {1'b1, 6'd14};
      {3'd4, 5'b10010}: lookup = {1'b1, 6'd15};
      {3'd4, 5'b00100}: lookup = {1'b1, 6'd16};
      {3'd3, 5'b10100}: lookup = {1'b1, 6'd17};
      {3'd3, 5'b11100}: lookup = {1'b1, 6'd18};
      {3'd1, 5'b00000}: lookup = {1'b1, 6'd19};
      {3'd3, 5'b11000}: lookup = {1'b1, 6'd20};
      {3'd4, 5'b11100}: lookup = {1'b1, 6'd21};
      {3'd3, 5'b10000}: lookup = {1'b1, 6'd22};
      {3'd4, 5'b01100}: lookup = {1'b1, 6'd23};
      {3'd4, 5'b01000}: lookup = {1'b1, 6'd24};
      {3'd4, 5'b00110}: lookup = {1'b1, 6'd25};
      {3'd5, 5'b00000}: lookup = {1'b1, 6'd26};
      {3'd5, 5'b10000}: lookup = {1'b1, 6'd27};
      {3'd5, 5'b11000}: lookup = {1'b1, 6'd28};
      {3'd5, 5'b11100}: lookup = {1'b1, 6'd29};
      {3'd5, 5'b11110}: lookup = {1'b1, 6'd30};
      {3'd5, 5'b11111}: lookup = {1'b1, 6'd31};
      {3'd5, 5'b01111}: lookup = {1'b1, 6'd32};
      {3'd5, 5'b00111}: lookup = {1'b1, 6'd33};
      {3'd5, 5'b00011}: lookup = {1'b1, 6'd34};
      {3'd5, 5'b00001}: lookup = {1'b1, 6'd35};
      default:          lookup = {1'b0, 6'h3F};
    endcase
  endfunction

  function automatic logic [4:0] mask(input logic [2:0] n);
    case (n)
      3'd1:    mask = 5'b10000;
      3'd2:    mask = 5'b11000;
      3'd3:    mask = 5'b11100;
      3'd4:    mask = 5'b11110;
      3'd5:    mask = 5'b11111;
      default: mask = 5'b00000;
    endcase
  endfunction

  assign lk = lookup(sym_cnt, pat);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      dur     <= '0;
      pat     <= '0;
      sym_cnt <= '0;
      ovf     <= 1'b0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      num     <= '0;
      morse   <= '0;
      display <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          sym_cnt <= '0;
          pat     <= '0;
          ovf     <= 1'b0;
          if (k) begin
            dur   <= '0;
            state <= PRESS;
          end
        end
        PRESS: begin
          if (!k) begin
            if (sym_cnt == 3'd5) begin
              ovf <= 1'b1;
            end else begin
              if (dur < DOT_MAX) pat <= pat | (5'b10000 >> sym_cnt);
              sym_cnt <= sym_cnt + 3'd1;
            end
            dur   <= '0;
            state <= GAP;
          end else if (tick_en) begin
            dur <= dur_inc;
          end
        end
        GAP: begin
          if (k) begin
            dur   <= '0;
            state <= PRESS;
          end else if (dur == GAP_LIM) begin
            state <= SEARCH;
          end else if (tick_en) begin
            dur <= dur_inc;
          end
        end
        SEARCH: begin
          hit_q <= lk[6] & ~ovf;
          idx_q <= lk[5:0];
          state <= DONE;
        end
        DONE: begin
          valid   <= 1'b1;
          morse   <= pat;
          display <= mask(sym_cnt);
          num     <= hit_q ? idx_q : 6'h3F;
          err     <= ~hit_q;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ponto = (state == PRESS) && (dur < DOT_MAX);
  assign traco = (state == PRESS) && !(dur < DOT_MAX);

endmodule

// File: tb/tb_decod_morse.sv
// tb/tb_decod_morse.sv - directed scoreboard bench for decod_morse.
module tb_decod_morse;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_in = 1'b0;
  logic [5:0] num;
  logic [4:0] morse;
  logic [4:0] display;
  logic       valid;
  logic       err;
  logic       ponto;
  logic       traco;

  typedef struct packed {
    logic [5:0] num;
    logic [4:0] morse;
    logic [4:0] disp;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic prev_valid = 1'b0;

  decod_morse #(
    .TICK_DIV(4), .DEBOUNCE_TK(2), .DOT_MAX_TK(5), .GAP_TK(15)
  ) dut (
    .clk(clk), .reset(reset), .key_in(key_in),
    .num(num), .morse(morse), .display(display),
    .valid(valid), .err(err), .ponto(ponto), .traco(traco)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (valid) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_valid got=valid exp=no_valid num=%0h", num);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("num", 32'(num), 32'(e.num));
        chk("morse", 32'(morse), 32'(e.morse));
        chk("display", 32'(display), 32'(e.disp));
        chk("err", 32'(err), 32'(e.err));
      end
    end
    if (prev_valid) chk("valid_width", 32'(valid), 32'd0);
    prev_valid = valid;
  end

  task automatic idle(input int t);
    repeat (4 * t) @(negedge clk);
  endtask

  task automatic press(input int t);
    @(negedge clk) key_in = 1'b1;
    repeat (4 * t) @(negedge clk);
    key_in = 1'b0;
  endtask

  // '.' = 2 ticks, '-' = 8 ticks, '4'/'5' = press of exactly that many ticks
  task automatic send(input string s, input logic [5:0] n, input logic [4:0] m,
                      input logic [4:0] d, input logic e);
    exp_t x;
    byte  c;
    x.num = n; x.morse = m; x.disp = d; x.err = e;
    sb.push_back(x);
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      case (c)
        8'h2E:   press(2);
        8'h2D:   press(8);
        8'h34:   press(4);
        default: press(5);
      endcase
      if (i != s.len() - 1) idle(4);
    end
    idle(25);
    chk({"pending_", s}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    exp_t x;
    repeat (3) @(negedge clk);
    chk("rst_num", 32'(num), 32'd0);
    chk("rst_morse", 32'(morse), 32'd0);
    chk("rst_display", 32'(display), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ponto", 32'(ponto), 32'd0);
    chk("rst_traco", 32'(traco), 32'd0);
    reset = 1'b1;
    idle(2);

    send(".-",     6'd0,  5'b10000, 5'b11000, 1'b0);
    send(".",      6'd4,  5'b10000, 5'b10000, 1'b0);
    send("-----",  6'd26, 5'b00000, 5'b11111, 1'b0);
    send(".....",  6'd31, 5'b11111, 5'b11111, 1'b0);
    send("-.-.",   6'd2,  5'b01010, 5'b11110, 1'b0);
    send("----.",  6'd35, 5'b00001, 5'b11111, 1'b0);
    send("......", 6'h3F, 5'b11111, 5'b11111, 1'b1);
    send("..--",   6'h3F, 5'b11000, 5'b11110, 1'b1);

    // bounces of one tick each must never reach the FSM
    for (int i = 0; i < 5; i++) begin
      press(1);
      idle(1);
    end
    idle(25);
    chk("bounce_display", 32'(display), 32'(5'b11110));

    send("4", 6'd4,  5'b10000, 5'b10000, 1'b0);
    send("5", 6'd19, 5'b00000, 5'b10000, 1'b0);
    send(".-.", 6'd17, 5'b10100, 5'b11100, 1'b0);

    press(2); idle(4); press(2); idle(4);
    @(negedge clk) reset = 1'b0;
    #1;
    chk("midrst_num", 32'(num), 32'd0);
    chk("midrst_morse", 32'(morse), 32'd0);
    chk("midrst_display", 32'(display), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    idle(25);

    x.num = 6'd19; x.morse = 5'b00000; x.disp = 5'b10000; x.err = 1'b0;
    sb.push_back(x);
    @(negedge clk) key_in = 1'b1;
    repeat (12) @(negedge clk);
    chk("live_ponto", 32'(ponto), 32'd1);
    chk("live_traco_early", 32'(traco), 32'd0);
    repeat (20) @(negedge clk);
    chk("live_traco", 32'(traco), 32'd1);
    chk("live_ponto_late", 32'(ponto), 32'd0);
    key_in = 1'b0;
    idle(25);
    chk("pending_T", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
